// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller and its neighbours.
package vend_pkg;

  localparam int CREDIT_W      = 3;
  localparam int MAX_CREDIT_Q  = 6;
  localparam int QUARTER_CENTS = 25;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DISPENSE  = 3'd1,
    CHANGE_HI = 3'd2,
    CHANGE_LO = 3'd3,
    CLEAR     = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/credit_decode.sv
// One-hot credit decode: index of the single set bit, or 0 with valid low when the
// input is not exactly one-hot.
module credit_decode
  import vend_pkg::*;
(
  input  logic [MAX_CREDIT_Q:0] q_i,
  output logic [CREDIT_W-1:0]   credit_o,
  output logic                  valid_o
);

  logic [CREDIT_W-1:0] ones_s;
  logic [CREDIT_W-1:0] idx_s;

  // count set bits and remember the last set index
  always_comb begin
    ones_s = 3'd0;
    idx_s  = 3'd0;
    for (int i = 0; i <= MAX_CREDIT_Q; i++) begin
      if (q_i[i]) begin
        ones_s = ones_s + 3'd1;
        idx_s  = CREDIT_W'(i);
      end else begin
        ones_s = ones_s;
        idx_s  = idx_s;
      end
    end
    valid_o = (ones_s == 3'd1);
    if (valid_o) begin
      credit_o = idx_s;
    end else begin
      credit_o = 3'd0;
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vend transaction sequencer: dispense strobe, one CHANGE pulse per returned quarter,
// then a single CLEAR back to the credit register. All outputs are registered.
module vend_dispense_ctrl #(
  parameter int unsigned PRICE_Q          = 32'd4,
  parameter int unsigned DISPENSE_CYCLES  = 32'd8,
  parameter int unsigned CHANGE_HI_CYCLES = 32'd4,
  parameter int unsigned CHANGE_LO_CYCLES = 32'd4
) (
  input  logic CLK,
  input  logic RST,
  input  logic Q0,
  input  logic Q1,
  input  logic Q2,
  input  logic Q3,
  input  logic Q4,
  input  logic Q5,
  input  logic Q6,
  input  logic VEND_REQ,
  input  logic COIN_RET,
  output logic DISPENSE,
  output logic CHANGE,
  output logic CLEAR,
  output logic BUSY,
  output logic DENY,
  output logic ONEHOT_ERR
);
  import vend_pkg::*;

  localparam int unsigned TMAX    = max3(DISPENSE_CYCLES, CHANGE_HI_CYCLES, CHANGE_LO_CYCLES);
  localparam int          TIMER_W = $clog2(TMAX + 32'd1);

  localparam logic [TIMER_W-1:0]  T_ZERO  = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0]  T_ONE   = TIMER_W'(32'd1);
  localparam logic [TIMER_W-1:0]  T_DISP  = TIMER_W'(DISPENSE_CYCLES);
  localparam logic [TIMER_W-1:0]  T_HI    = TIMER_W'(CHANGE_HI_CYCLES);
  localparam logic [TIMER_W-1:0]  T_LO    = TIMER_W'(CHANGE_LO_CYCLES);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_Q);

  logic [CREDIT_W-1:0] credit_s;
  logic                valid_s;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CREDIT_W-1:0] chg_q, chg_d;
  logic                deny_d;
  logic                dispense_d, change_d, clear_d, busy_d;
  logic                dispense_q, change_q, clear_q, busy_q, deny_q, onehot_err_q;

  credit_decode u_credit_decode (
    .q_i      ({Q6, Q5, Q4, Q3, Q2, Q1, Q0}),
    .credit_o (credit_s),
    .valid_o  (valid_s)
  );

  // state, timer and change-count registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= vend_pkg::IDLE;
      timer_q <= T_ZERO;
      chg_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chg_q   <= chg_d;
    end
  end

  // next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    chg_d   = chg_q;
    deny_d  = 1'b0;
    case (state_q)
      vend_pkg::IDLE: begin
        if (VEND_REQ && (credit_s >= PRICE_C)) begin
          chg_d   = credit_s - PRICE_C;
          timer_d = T_DISP;
          state_d = vend_pkg::DISPENSE;
        end else if (COIN_RET && (credit_s != 3'd0)) begin
          chg_d   = credit_s;
          timer_d = T_HI;
          state_d = vend_pkg::CHANGE_HI;
          deny_d  = VEND_REQ;
        end else begin
          deny_d  = VEND_REQ;
        end
      end
      vend_pkg::DISPENSE: begin
        if (timer_q == T_ONE) begin
          if (chg_q != 3'd0) begin
            timer_d = T_HI;
            state_d = vend_pkg::CHANGE_HI;
          end else begin
            timer_d = T_ZERO;
            state_d = vend_pkg::CLEAR;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      vend_pkg::CHANGE_HI: begin
        if (timer_q == T_ONE) begin
          chg_d   = chg_q - 3'd1;
          timer_d = T_LO;
          state_d = vend_pkg::CHANGE_LO;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      vend_pkg::CHANGE_LO: begin
        if (timer_q == T_ONE) begin
          if (chg_q != 3'd0) begin
            timer_d = T_HI;
            state_d = vend_pkg::CHANGE_HI;
          end else begin
            timer_d = T_ZERO;
            state_d = vend_pkg::CLEAR;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      vend_pkg::CLEAR: begin
        state_d = vend_pkg::IDLE;
      end
      default: begin
        state_d = vend_pkg::IDLE;
        timer_d = T_ZERO;
        chg_d   = 3'd0;
      end
    endcase
  end

  // Moore outputs decoded from the next state so the registered copies line up with state_q
  always_comb begin
    dispense_d = (state_d == vend_pkg::DISPENSE);
    change_d   = (state_d == vend_pkg::CHANGE_HI);
    clear_d    = (state_d == vend_pkg::CLEAR);
    busy_d     = (state_d != vend_pkg::IDLE);
  end

  // output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      dispense_q   <= 1'b0;
      change_q     <= 1'b0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      deny_q       <= 1'b0;
      onehot_err_q <= 1'b0;
    end else begin
      dispense_q   <= dispense_d;
      change_q     <= change_d;
      clear_q      <= clear_d;
      busy_q       <= busy_d;
      deny_q       <= deny_d;
      onehot_err_q <= ~valid_s;
    end
  end

  assign DISPENSE   = dispense_q;
  assign CHANGE     = change_q;
  assign CLEAR      = clear_q;
  assign BUSY       = busy_q;
  assign DENY       = deny_q;
  assign ONEHOT_ERR = onehot_err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed, table-driven bench for vend_dispense_ctrl with default parameters (price $1.00).
module tb_vend_dispense_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] q;
  logic       vend, coin;
  logic       DISPENSE, CHANGE, CLEAR, BUSY, DENY, ONEHOT_ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  vend_dispense_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .Q0         (q[0]),
    .Q1         (q[1]),
    .Q2         (q[2]),
    .Q3         (q[3]),
    .Q4         (q[4]),
    .Q5         (q[5]),
    .Q6         (q[6]),
    .VEND_REQ   (vend),
    .COIN_RET   (coin),
    .DISPENSE   (DISPENSE),
    .CHANGE     (CHANGE),
    .CLEAR      (CLEAR),
    .BUSY       (BUSY),
    .DENY       (DENY),
    .ONEHOT_ERR (ONEHOT_ERR)
  );

  typedef struct {
    logic [6:0] q;
    logic       vend, coin;
    logic       deny, busy, disp, chg, err;
    int         len, pulses, dispc;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [6:0] qv, input logic v, input logic c,
                              input logic d, input logic b, input logic ds,
                              input logic ch, input logic e, input int len,
                              input int p, input int dc);
    vec_t r;
    r.q = qv; r.vend = v; r.coin = c;
    r.deny = d; r.busy = b; r.disp = ds; r.chg = ch; r.err = e;
    r.len = len; r.pulses = p; r.dispc = dc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Follows a transaction until BUSY drops (bounded), counting what it sees.
  task automatic run_busy(output int n, output int dc, output int pc, output int cc,
                          output int dn);
    logic prev;
    n = 0; dc = 0; pc = 0; cc = 0; dn = 0; prev = 1'b0;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      if (DISPENSE) dc++;
      if (CHANGE && !prev) pc++;
      if (CLEAR) cc++;
      if (DENY) dn++;
      prev = CHANGE;
      tick();
    end
  endtask

  initial begin
    int n, dc, pc, cc, dn;
    logic [3:0] expw;

    // q, vend, coin | deny, busy, disp, chg, err | busy cycles, change pulses, dispense cycles
    vecs[0]  = mk(7'b0000001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0);
    vecs[1]  = mk(7'b0000100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0);
    vecs[2]  = mk(7'b0000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0);
    vecs[3]  = mk(7'b0001000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 25, 3, 0);
    vecs[4]  = mk(7'b0010000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  9, 0, 8);
    vecs[5]  = mk(7'b1000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 25, 2, 8);
    vecs[6]  = mk(7'b0100000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17, 1, 8);
    vecs[7]  = mk(7'b0000100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 17, 2, 0);
    vecs[8]  = mk(7'b0001010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 0);
    vecs[9]  = mk(7'b0000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 0);
    vecs[10] = mk(7'b0001000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 0);
    vecs[11] = mk(7'b1000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 49, 6, 0);

    // reset with an invalid credit so ONEHOT_ERR would otherwise be set
    RST = 1'b1; q = 7'b0000000; vend = 1'b0; coin = 1'b0;
    tick(); tick();
    check("reset outputs", {DISPENSE, CHANGE, CLEAR, BUSY, DENY, ONEHOT_ERR}, 6'b000000);
    q = 7'b0000001;
    RST = 1'b0;
    tick();
    check("idle outputs", {DISPENSE, CHANGE, CLEAR, BUSY, DENY, ONEHOT_ERR}, 6'b000000);

    for (int i = 0; i < 12; i++) begin
      q = vecs[i].q; vend = vecs[i].vend; coin = vecs[i].coin;
      tick();
      vend = 1'b0; coin = 1'b0;
      check($sformatf("vec%0d deny", i), DENY, vecs[i].deny);
      check($sformatf("vec%0d busy", i), BUSY, vecs[i].busy);
      check($sformatf("vec%0d dispense", i), DISPENSE, vecs[i].disp);
      check($sformatf("vec%0d change", i), CHANGE, vecs[i].chg);
      check($sformatf("vec%0d onehot_err", i), ONEHOT_ERR, vecs[i].err);
      run_busy(n, dc, pc, cc, dn);
      check($sformatf("vec%0d busy cycles", i), n, vecs[i].len);
      check($sformatf("vec%0d change pulses", i), pc, vecs[i].pulses);
      check($sformatf("vec%0d dispense cycles", i), dc, vecs[i].dispc);
      check($sformatf("vec%0d clear cycles", i), cc, vecs[i].busy ? 1 : 0);
    end

    // Q6 vend: cycle-by-cycle {BUSY, DISPENSE, CHANGE, CLEAR}
    q = 7'b1000000; vend = 1'b1;
    tick();
    vend = 1'b0;
    for (int i = 0; i < 26; i++) begin
      expw[3] = (i < 25);
      expw[2] = (i < 8);
      expw[1] = (i >= 8) && (i < 24) && (((i - 8) % 8) < 4);
      expw[0] = (i == 24);
      check($sformatf("q6 wave cyc%0d", i), {BUSY, DISPENSE, CHANGE, CLEAR}, expw);
      tick();
    end

    // Q4 vend+coin: vend wins with no change; a second vend in DISPENSE cycle 3 is dropped
    q = 7'b0010000; vend = 1'b1; coin = 1'b1;
    tick();
    vend = 1'b0; coin = 1'b0;
    check("q4 both dispense", {DISPENSE, CHANGE, DENY}, 3'b100);
    tick(); tick();
    vend = 1'b1; q = 7'b1000000;
    tick();
    vend = 1'b0;
    run_busy(n, dc, pc, cc, dn);
    check("q4 busy cycles", n + 3, 9);
    check("q4 dispense cycles", dc + 3, 8);
    check("q4 change pulses", pc, 0);
    check("q4 clear cycles", cc, 1);
    check("q4 deny while busy", dn, 0);
    tick();
    check("q4 no queued vend", BUSY, 1'b0);

    // invalid one-hot: error flag, credit treated as 0, recovery on valid Q5
    q = 7'b0001010;
    tick();
    check("onehot err set", ONEHOT_ERR, 1'b1);
    vend = 1'b1;
    tick();
    vend = 1'b0;
    check("onehot deny", {DENY, BUSY, DISPENSE}, 3'b100);
    q = 7'b0100000;
    tick();
    check("deny single cycle", DENY, 1'b0);
    check("onehot err cleared", ONEHOT_ERR, 1'b0);

    // reset during DISPENSE cycle 3 aborts without a CLEAR
    q = 7'b1000000; vend = 1'b1;
    tick();
    vend = 1'b0;
    check("rst test dispense", DISPENSE, 1'b1);
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid reset outputs", {DISPENSE, CHANGE, CLEAR, BUSY, DENY, ONEHOT_ERR}, 6'b000000);
    n = 0; cc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (BUSY) n++;
      if (CLEAR) cc++;
    end
    check("post reset busy", n, 0);
    check("post reset clear", cc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
